// File: rtl/screen_sequencer.sv
// Game-flow controller: picks start / game / game-over screen and applies each
// change only at the first cycle of vertical blanking.
module screen_sequencer #(
  parameter int BTN_X          = 373,
  parameter int BTN_Y          = 274,
  parameter int BTN_W          = 54,
  parameter int BTN_H          = 53,
  parameter int HOLDOFF_FRAMES = 30,
  parameter int OVER_FRAMES    = 180
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        vblnk,
  input  logic        game_over,
  output logic [1:0]  screen_sel,
  output logic        game_rst,
  output logic        game_en,
  output logic [15:0] play_frames,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_ARM_PLAY  = 3'd1,
    S_PLAYING   = 3'd2,
    S_ARM_OVER  = 3'd3,
    S_OVER      = 3'd4,
    S_ARM_START = 3'd5
  } state_t;

  localparam logic [1:0]  SEL_START = 2'd0;
  localparam logic [1:0]  SEL_GAME  = 2'd1;
  localparam logic [1:0]  SEL_OVER  = 2'd2;
  localparam logic [11:0] X_LO      = 12'(BTN_X);
  localparam logic [11:0] X_HI      = 12'(BTN_X + BTN_W);
  localparam logic [11:0] Y_LO      = 12'(BTN_Y);
  localparam logic [11:0] Y_HI      = 12'(BTN_Y + BTN_H);
  localparam logic [7:0]  HOLDOFF   = 8'(HOLDOFF_FRAMES);
  localparam logic [7:0]  OVER_LIM  = 8'(OVER_FRAMES);

  state_t      state, state_nx;
  logic        ml_d, vb_d;
  logic [7:0]  over_cnt, oc_nx;
  logic [1:0]  sel_nx;
  logic        grst_nx, en_nx;
  logic [15:0] pf_nx;
  logic        click, frame_start, hit;

  // Edge detectors reset high so levels already present at reset release
  // are not mistaken for fresh edges.
  assign click       = mouse_left & ~ml_d;
  assign frame_start = vblnk & ~vb_d;
  assign hit         = (xpos >= X_LO) && (xpos < X_HI) &&
                       (ypos >= Y_LO) && (ypos < Y_HI);
  assign state_dbg   = state;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state       <= S_START;
      ml_d        <= 1'b1;
      vb_d        <= 1'b1;
      over_cnt    <= 8'd0;
      screen_sel  <= SEL_START;
      game_rst    <= 1'b0;
      game_en     <= 1'b0;
      play_frames <= 16'd0;
    end else begin
      state       <= state_nx;
      ml_d        <= mouse_left;
      vb_d        <= vblnk;
      over_cnt    <= oc_nx;
      screen_sel  <= sel_nx;
      game_rst    <= grst_nx;
      game_en     <= en_nx;
      play_frames <= pf_nx;
    end
  end

  // ARM_* states only wait for the next blanking edge; events seen while
  // armed are deliberately dropped.
  always_comb begin
    state_nx = state;
    sel_nx   = screen_sel;
    grst_nx  = 1'b0;
    en_nx    = game_en;
    pf_nx    = play_frames;
    oc_nx    = over_cnt;
    unique case (state)
      S_START: begin
        if (click && hit) state_nx = S_ARM_PLAY;
      end
      S_ARM_PLAY: begin
        if (frame_start) begin
          state_nx = S_PLAYING;
          sel_nx   = SEL_GAME;
          en_nx    = 1'b1;
          grst_nx  = 1'b1;
          pf_nx    = 16'd0;
        end
      end
      S_PLAYING: begin
        if (frame_start && (play_frames != 16'hFFFF)) pf_nx = play_frames + 16'd1;
        if (game_over) state_nx = S_ARM_OVER;
      end
      S_ARM_OVER: begin
        if (frame_start) begin
          state_nx = S_OVER;
          sel_nx   = SEL_OVER;
          en_nx    = 1'b0;
          oc_nx    = 8'd0;
        end
      end
      S_OVER: begin
        if (frame_start && (over_cnt != 8'hFF)) oc_nx = over_cnt + 8'd1;
        if ((click && (over_cnt >= HOLDOFF)) || (over_cnt == OVER_LIM))
          state_nx = S_ARM_START;
      end
      S_ARM_START: begin
        if (frame_start) begin
          state_nx = S_START;
          sel_nx   = SEL_START;
        end
      end
      default: state_nx = S_START;
    endcase
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: a monitor pops expected screen values
// on every screen change and checks it lands one cycle after the vblnk rise.
module tb_screen_sequencer;

  localparam logic [2:0] ST_START     = 3'd0;
  localparam logic [2:0] ST_ARM_PLAY  = 3'd1;
  localparam logic [2:0] ST_PLAYING   = 3'd2;
  localparam logic [2:0] ST_ARM_OVER  = 3'd3;
  localparam logic [2:0] ST_OVER      = 3'd4;
  localparam logic [2:0] ST_ARM_START = 3'd5;

  logic        pclk = 1'b0;
  logic        rst;
  logic        mouse_left;
  logic [11:0] xpos, ypos;
  logic        vblnk;
  logic        game_over;
  logic [1:0]  screen_sel;
  logic        game_rst;
  logic        game_en;
  logic [15:0] play_frames;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int grst_cnt = 0;
  logic [1:0] exp_q[$];

  screen_sequencer dut (
    .pclk        (pclk),
    .rst         (rst),
    .mouse_left  (mouse_left),
    .xpos        (xpos),
    .ypos        (ypos),
    .vblnk       (vblnk),
    .game_over   (game_over),
    .screen_sel  (screen_sel),
    .game_rst    (game_rst),
    .game_en     (game_en),
    .play_frames (play_frames),
    .state_dbg   (state_dbg)
  );

  // clock / watchdog
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vblnk = 1'b1;
      tick(3);
      vblnk = 1'b0;
      tick(6);
    end
  endtask

  task automatic click_at(input logic [11:0] x, input logic [11:0] y);
    xpos = x;
    ypos = y;
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    tick(1);
  endtask

  // scoreboard monitor
  logic [1:0] prev_sel = 2'd0;
  logic       vb_h1 = 1'b1;
  logic       vb_h2 = 1'b1;

  always @(negedge pclk) begin
    if (!rst) begin
      prev_sel = 2'd0;
      vb_h1 = 1'b1;
      vb_h2 = 1'b1;
    end else begin
      if (screen_sel !== prev_sel) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sel_unexpected observed=%0d expected=%0d", screen_sel, prev_sel);
        end
        if (exp_q.size() != 0) chk("sel_seq", 32'(screen_sel), 32'(exp_q.pop_front()));
        chk("swap_at_f1", 32'({vb_h2, vb_h1}), 32'(2'b01));
      end
      if (game_rst) begin
        grst_cnt++;
        chk("grst_on_entry", 32'({screen_sel != prev_sel, screen_sel, game_en}), 32'(4'b1011));
      end
      prev_sel = screen_sel;
      vb_h2 = vb_h1;
      vb_h1 = vblnk;
    end
  end

  initial begin
    rst = 1'b0;
    mouse_left = 1'b1;
    vblnk = 1'b1;
    xpos = 12'd373;
    ypos = 12'd274;
    game_over = 1'b0;
    tick(3);
    chk("rst_outputs", 32'({screen_sel, game_rst, game_en, play_frames}), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_START));

    // release with button and blank already high: no edge may be seen
    rst = 1'b1;
    tick(3);
    chk("rel_outputs", 32'({screen_sel, game_rst, game_en, play_frames}), 32'd0);
    chk("rel_state", 32'(state_dbg), 32'(ST_START));
    mouse_left = 1'b0;
    vblnk = 1'b0;
    tick(2);
    frames(2);
    chk("rel_no_swap", 32'({state_dbg, screen_sel}), 32'({ST_START, 2'd0}));

    // misses and ignored game_over
    click_at(12'd427, 12'd274);
    chk("miss_x_hi", 32'(state_dbg), 32'(ST_START));
    click_at(12'd372, 12'd300);
    chk("miss_x_lo", 32'(state_dbg), 32'(ST_START));
    click_at(12'd400, 12'd327);
    chk("miss_y_hi", 32'(state_dbg), 32'(ST_START));
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    tick(1);
    chk("go_in_start", 32'(state_dbg), 32'(ST_START));
    frames(1);
    chk("miss_sel", 32'(screen_sel), 32'd0);

    // start click at the button corner
    click_at(12'd373, 12'd274);
    chk("arm_play", 32'({state_dbg, screen_sel}), 32'({ST_ARM_PLAY, 2'd0}));
    exp_q.push_back(2'd1);
    vblnk = 1'b1;
    tick(1);
    chk("enter_game", 32'({screen_sel, game_rst, game_en, play_frames}), 32'({2'd1, 1'b1, 1'b1, 16'd0}));
    chk("enter_state", 32'(state_dbg), 32'(ST_PLAYING));
    tick(1);
    chk("grst_fall", 32'({game_rst, game_en}), 32'(2'b01));
    tick(1);
    vblnk = 1'b0;
    tick(6);

    // five frames then game over
    frames(5);
    chk("play_frames5", 32'(play_frames), 32'd5);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    chk("arm_over", 32'({state_dbg, screen_sel}), 32'({ST_ARM_OVER, 2'd1}));
    exp_q.push_back(2'd2);
    frames(1);
    chk("over_outputs", 32'({screen_sel, game_en, play_frames}), 32'({2'd2, 1'b0, 16'd5}));
    chk("over_state", 32'(state_dbg), 32'(ST_OVER));
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    tick(1);
    chk("go_in_over", 32'(state_dbg), 32'(ST_OVER));
    frames(2);
    chk("pf_held", 32'(play_frames), 32'd5);

    // hold-off: frames 10 and 29 ignored, 30 accepted
    frames(8);
    click_at(12'd0, 12'd0);
    chk("holdoff_10", 32'(state_dbg), 32'(ST_OVER));
    frames(19);
    click_at(12'd0, 12'd0);
    chk("holdoff_29", 32'(state_dbg), 32'(ST_OVER));
    frames(1);
    click_at(12'd0, 12'd0);
    chk("holdoff_30", 32'(state_dbg), 32'(ST_ARM_START));
    exp_q.push_back(2'd0);
    frames(1);
    chk("back_start", 32'({state_dbg, screen_sel, play_frames}), 32'({ST_START, 2'd0, 16'd5}));

    // click in the same cycle as the vblnk rise
    xpos = 12'd373;
    ypos = 12'd274;
    mouse_left = 1'b1;
    vblnk = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    chk("simul_arm", 32'({state_dbg, screen_sel, game_rst}), 32'({ST_ARM_PLAY, 2'd0, 1'b0}));
    tick(2);
    vblnk = 1'b0;
    tick(6);
    chk("simul_no_swap", 32'(screen_sel), 32'd0);
    exp_q.push_back(2'd1);
    frames(1);
    chk("simul_swap", 32'({screen_sel, play_frames}), 32'({2'd1, 16'd0}));

    // automatic return after 180 frames on game over
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    exp_q.push_back(2'd2);
    frames(1);
    chk("auto_enter", 32'({state_dbg, screen_sel}), 32'({ST_OVER, 2'd2}));
    frames(179);
    chk("auto_179", 32'(state_dbg), 32'(ST_OVER));
    frames(1);
    chk("auto_180", 32'({state_dbg, screen_sel}), 32'({ST_ARM_START, 2'd2}));
    exp_q.push_back(2'd0);
    frames(1);
    chk("auto_start", 32'({state_dbg, screen_sel}), 32'({ST_START, 2'd0}));

    // reset while armed: no swap, no pulse
    click_at(12'd426, 12'd326);
    chk("corner_hit", 32'(state_dbg), 32'(ST_ARM_PLAY));
    rst = 1'b0;
    #2;
    chk("arm_rst_out", 32'({screen_sel, game_rst, game_en, play_frames}), 32'd0);
    chk("arm_rst_state", 32'(state_dbg), 32'(ST_START));
    tick(2);
    rst = 1'b1;
    tick(1);
    frames(2);
    chk("arm_rst_after", 32'({state_dbg, screen_sel}), 32'({ST_START, 2'd0}));
    chk("grst_count", 32'(grst_cnt), 32'd2);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
